// File: rtl/snn_spike_count_decoder.sv
// Spike-count readout for the SNN output layer: accumulates saturating per-neuron
// counts over a programmable number of timesteps and reports argmax via valid/ready.
module snn_spike_count_decoder #(
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned CLS_W   = 1,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned WIN_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     timestep_tick,
    input  logic [NUM_OUT-1:0]       output_spikes,
    input  logic [WIN_W-1:0]         window_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLS_W-1:0]         class_id,
    output logic                     tie,
    output logic [NUM_OUT*CNT_W-1:0] spike_counts,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt     [NUM_OUT];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_OUT];
    logic [WIN_W-1:0] r_step;
    logic [WIN_W-1:0] r_len;
    logic [WIN_W-1:0] w_step_nxt;
    logic [WIN_W-1:0] w_len_new;
    logic [CNT_W-1:0] w_max;
    logic [CLS_W-1:0] w_cls;
    logic             w_tie;
    logic             w_seen;

    assign w_step_nxt = r_step + WIN_W'(1);
    assign w_len_new  = (window_len == '0) ? WIN_W'(1) : window_len;

    // Counter values including the current sample, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (output_spikes[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // Argmax on the post-sample counts; strict '>' keeps the lowest index on ties.
    always_comb begin
        w_max  = w_cnt_nxt[0];
        w_cls  = '0;
        w_tie  = 1'b0;
        w_seen = 1'b0;
        for (int i = 1; i < int'(NUM_OUT); i++) begin
            if (w_cnt_nxt[i] > w_max) begin
                w_max = w_cnt_nxt[i];
                w_cls = CLS_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (w_cnt_nxt[i] == w_max) begin
                if (w_seen) begin
                    w_tie = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_len        <= WIN_W'(1);
            out_valid    <= 1'b0;
            class_id     <= '0;
            tie          <= 1'b0;
            spike_counts <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        for (int i = 0; i < int'(NUM_OUT); i++) begin
                            r_cnt[i] <= '0;
                        end
                        r_step  <= '0;
                        r_len   <= w_len_new;
                        busy    <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (!enable) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (timestep_tick) begin
                        for (int i = 0; i < int'(NUM_OUT); i++) begin
                            r_cnt[i] <= w_cnt_nxt[i];
                        end
                        r_step <= w_step_nxt;
                        // Final sample of the window: publish straight from the next-count view.
                        if (w_step_nxt == r_len) begin
                            for (int i = 0; i < int'(NUM_OUT); i++) begin
                                spike_counts[i*CNT_W +: CNT_W] <= w_cnt_nxt[i];
                            end
                            class_id  <= w_cls;
                            tie       <= w_tie;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    overrun <= timestep_tick;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (enable) begin
                            for (int i = 0; i < int'(NUM_OUT); i++) begin
                                r_cnt[i] <= '0;
                            end
                            r_step  <= '0;
                            r_len   <= w_len_new;
                            busy    <= 1'b1;
                            r_state <= S_ACCUM;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_spike_count_decoder.sv
// Bench for snn_spike_count_decoder: two instances (8-bit and 4-bit counters) share
// stimulus; a window-level model is checked every cycle plus literal spot checks.
module tb_snn_spike_count_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       tick = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] spk = 2'b00;
    logic [7:0] wl = 8'd0;

    logic        va, tie_a, busy_a, ovr_a;
    logic [0:0]  cls_a;
    logic [15:0] cnt_a;
    logic        vb, tie_b, busy_b, ovr_b;
    logic [0:0]  cls_b;
    logic [7:0]  cnt_b;

    always #5 clk = ~clk;

    snn_spike_count_decoder #(.NUM_OUT(2), .CLS_W(1), .CNT_W(8), .WIN_W(8)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .timestep_tick(tick),
        .output_spikes(spk), .window_len(wl), .out_valid(va), .out_ready(out_ready),
        .class_id(cls_a), .tie(tie_a), .spike_counts(cnt_a), .busy(busy_a), .overrun(ovr_a));

    snn_spike_count_decoder #(.NUM_OUT(2), .CLS_W(1), .CNT_W(4), .WIN_W(8)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .timestep_tick(tick),
        .output_spikes(spk), .window_len(wl), .out_valid(vb), .out_ready(out_ready),
        .class_id(cls_b), .tie(tie_b), .spike_counts(cnt_b), .busy(busy_b), .overrun(ovr_b));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 idle, 1 accumulating, 2 holding result. Raw counts are unbounded;
    // each instance sees them clipped to its own counter maximum.
    int mode = 0;
    int raw [2] = '{0, 0};
    int steps = 0;
    int len = 1;
    int maxv [2] = '{255, 15};
    bit e_valid = 0, e_busy = 0, e_ovr = 0;
    int e_cls [2] = '{0, 0};
    bit e_tie [2] = '{0, 0};
    int e_cnt [2][2] = '{'{0, 0}, '{0, 0}};

    task automatic publish();
        for (int k = 0; k < 2; k++) begin
            int c [2];
            int best;
            int n_at_best;
            for (int n = 0; n < 2; n++) c[n] = (raw[n] < maxv[k]) ? raw[n] : maxv[k];
            best = (c[0] > c[1]) ? c[0] : c[1];
            n_at_best = 0;
            e_cls[k] = -1;
            for (int n = 0; n < 2; n++) begin
                if (c[n] == best) begin
                    n_at_best++;
                    if (e_cls[k] < 0) e_cls[k] = n;
                end
                e_cnt[k][n] = c[n];
            end
            e_tie[k] = (n_at_best >= 2);
        end
    endtask

    task automatic start_window();
        raw[0] = 0;
        raw[1] = 0;
        steps = 0;
        len = (wl == 8'd0) ? 1 : int'(wl);
        mode = 1;
        e_busy = 1;
    endtask

    task automatic model_update();
        if (reset) begin
            mode = 0; raw[0] = 0; raw[1] = 0; steps = 0;
            e_valid = 0; e_busy = 0; e_ovr = 0;
            for (int k = 0; k < 2; k++) begin
                e_cls[k] = 0; e_tie[k] = 0; e_cnt[k][0] = 0; e_cnt[k][1] = 0;
            end
        end else begin
            e_ovr = 0;
            if (mode == 0) begin
                if (enable) start_window();
            end else if (mode == 1) begin
                if (!enable) begin
                    mode = 0;
                    e_busy = 0;
                end else if (tick) begin
                    raw[0] += int'(spk[0]);
                    raw[1] += int'(spk[1]);
                    steps++;
                    if (steps == len) begin
                        publish();
                        e_valid = 1;
                        e_busy = 0;
                        mode = 2;
                    end
                end
            end else begin
                if (tick) e_ovr = 1;
                if (out_ready) begin
                    e_valid = 0;
                    if (enable) start_window();
                    else mode = 0;
                end
            end
        end
    endtask

    // Model advances on the edge with stable inputs; outputs compared 1 ns later.
    initial forever begin
        @(posedge clk);
        model_update();
        #1;
        chk("a.out_valid", 32'(va), 32'(e_valid));
        chk("a.busy", 32'(busy_a), 32'(e_busy));
        chk("a.overrun", 32'(ovr_a), 32'(e_ovr));
        chk("a.class_id", 32'(cls_a), 32'(e_cls[0]));
        chk("a.tie", 32'(tie_a), 32'(e_tie[0]));
        chk("a.cnt0", 32'(cnt_a[7:0]), 32'(e_cnt[0][0]));
        chk("a.cnt1", 32'(cnt_a[15:8]), 32'(e_cnt[0][1]));
        chk("b.out_valid", 32'(vb), 32'(e_valid));
        chk("b.busy", 32'(busy_b), 32'(e_busy));
        chk("b.overrun", 32'(ovr_b), 32'(e_ovr));
        chk("b.class_id", 32'(cls_b), 32'(e_cls[1]));
        chk("b.tie", 32'(tie_b), 32'(e_tie[1]));
        chk("b.cnt0", 32'(cnt_b[3:0]), 32'(e_cnt[1][0]));
        chk("b.cnt1", 32'(cnt_b[7:4]), 32'(e_cnt[1][1]));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tk(input logic [1:0] s);
        tick = 1'b1;
        spk = s;
        cyc(1);
        tick = 1'b0;
        spk = 2'b00;
    endtask

    task automatic handshake(input logic [7:0] next_len);
        wl = next_len;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    int ov_seen;

    initial begin
        cyc(2);
        chk("reset.valid", 32'(va), 32'd0);
        chk("reset.counts", 32'(cnt_a), 32'd0);
        chk("reset.busy", 32'(busy_a), 32'd0);
        reset = 1'b0;

        // Basic window of 4: neuron1 wins 4 to 1
        wl = 8'd4;
        enable = 1'b1;
        cyc(1);
        chk("t1.busy", 32'(busy_a), 32'd1);
        tk(2'b10); tk(2'b10); tk(2'b11); tk(2'b10);
        chk("t1.valid", 32'(va), 32'd1);
        chk("t1.counts", 32'(cnt_a), 32'h0401);
        chk("t1.counts_b", 32'(cnt_b), 32'h41);
        chk("t1.class", 32'(cls_a), 32'd1);
        chk("t1.tie", 32'(tie_a), 32'd0);

        // Tie on equal counts, then all-zero window
        handshake(8'd2);
        tk(2'b11); tk(2'b11);
        chk("t2.counts", 32'(cnt_a), 32'h0202);
        chk("t2.class", 32'(cls_a), 32'd0);
        chk("t2.tie", 32'(tie_a), 32'd1);
        handshake(8'd3);
        tk(2'b00); tk(2'b00); tk(2'b00);
        chk("t2z.counts", 32'(cnt_a), 32'h0000);
        chk("t2z.tie", 32'(tie_a), 32'd1);

        // Long window: 8-bit counter reaches 255, 4-bit sticks at 15
        handshake(8'd255);
        repeat (255) tk(2'b01);
        chk("t3.counts_a", 32'(cnt_a), 32'h00FF);
        chk("t3.counts_b", 32'(cnt_b), 32'h0F);
        chk("t3.class_b", 32'(cls_b), 32'd0);
        chk("t3.tie_b", 32'(tie_b), 32'd0);

        // Held result with ticks arriving: overrun pulses, outputs stable
        wl = 8'd4;
        ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick = (i == 2 || i == 5 || i == 8);
            spk = 2'b11;
            cyc(1);
            tick = 1'b0;
            spk = 2'b00;
            ov_seen += int'(ovr_a);
        end
        chk("t4.overrun_pulses", 32'(ov_seen), 32'd3);
        chk("t4.held_counts", 32'(cnt_a), 32'h00FF);
        out_ready = 1'b1;
        tick = 1'b1;
        spk = 2'b11;
        cyc(1);
        out_ready = 1'b0;
        tick = 1'b0;
        spk = 2'b00;
        chk("t4.valid_after_hs", 32'(va), 32'd0);
        chk("t4.busy_after_hs", 32'(busy_a), 32'd1);
        chk("t4.ovr_on_hs", 32'(ovr_a), 32'd1);
        tk(2'b01); tk(2'b01); tk(2'b01); tk(2'b01);
        chk("t4.next_counts", 32'(cnt_a), 32'h0004);
        chk("t4.next_valid", 32'(va), 32'd1);

        // Abort mid-window: no result, previous result kept
        handshake(8'd4);
        tk(2'b10); tk(2'b10);
        enable = 1'b0;
        cyc(1);
        chk("t5.busy", 32'(busy_a), 32'd0);
        tk(2'b10); tk(2'b10); tk(2'b10);
        chk("t5.valid", 32'(va), 32'd0);
        chk("t5.counts_kept", 32'(cnt_a), 32'h0004);

        // window_len=0 closes after one tick, then reset out of HOLD
        wl = 8'd0;
        enable = 1'b1;
        cyc(1);
        tk(2'b10);
        chk("t6.valid", 32'(va), 32'd1);
        chk("t6.counts", 32'(cnt_a), 32'h0100);
        chk("t6.class", 32'(cls_a), 32'd1);
        reset = 1'b1;
        cyc(1);
        chk("t6.rst_valid", 32'(va), 32'd0);
        chk("t6.rst_counts", 32'(cnt_a), 32'd0);
        chk("t6.rst_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        enable = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snn_spike_count_decoder.md
Name: snn_spike_count_decoder

Overview:
- Readout-side consumer of the SNN output layer; sits downstream of the spiking core's `output_spikes` bus.
- Samples the output spike vector once per SNN timestep and accumulates a saturating spike count per output neuron over a programmable window.
- At window end, emits the winning class (argmax), a tie flag and the raw counts through a valid/ready handshake.

Parameters:
- NUM_OUT, 2, number of output neurons/classes sampled.
- CLS_W, 1, width of class_id; must satisfy 2**CLS_W >= NUM_OUT.
- CNT_W, 8, width of each per-neuron spike counter.
- WIN_W, 8, width of the window-length configuration.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; while high the block accumulates windows back-to-back.
- timestep_tick  in  1  one-cycle pulse marking an SNN timestep sample point.
- output_spikes  in  NUM_OUT  spike vector from the SNN output layer, sampled only on timestep_tick.
- window_len  in  WIN_W  timesteps per window; latched at window start; 0 treated as 1.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- class_id  out  CLS_W  index of the neuron with the highest count.
- tie  out  1  maximum count shared by two or more neurons.
- spike_counts  out  NUM_OUT*CNT_W  final counts; neuron i at bits [i*CNT_W +: CNT_W].
- busy  out  1  high in ACCUM state.
- overrun  out  1  one-cycle pulse when a tick arrives while a result is held unaccepted.

Behaviour:
- Reset values: out_valid=0, class_id=0, tie=0, spike_counts=0, busy=0, overrun=0.
- Reset leaves the FSM in IDLE and clears the internal counters and step count.
- Reset mid-operation discards any partial window or held result immediately.
- IDLE:
  - When enable=1, clear counters and step count, latch window_len (0 becomes 1), go to ACCUM on the next cycle.
  - Ticks seen in IDLE are ignored.
- ACCUM (busy=1):
  - On each cycle with timestep_tick=1, counter[i] += output_spikes[i] for every i, saturating at 2**CNT_W-1.
  - On the same ticks, step count += 1.
  - On the tick that brings step count to the latched length, that tick's spikes are included. The next cycle then:
    - spike_counts, class_id and tie are registered;
    - out_valid=1;
    - the FSM goes to HOLD.
  - Result latency is 1 clock after the final tick.
  - If enable drops in ACCUM, abort to IDLE with no result; outputs keep their previous values.
- HOLD:
  - out_valid stays high and class_id, tie and spike_counts stay stable until out_valid && out_ready.
  - Ticks in HOLD are not counted; each pulses overrun for 1 cycle, registered.
  - On handshake:
    - if enable=1, go directly to ACCUM with cleared counters and a fresh window_len latch;
    - else go to IDLE.
  - out_valid drops in the cycle after the handshake.
  - A tick coincident with the handshake cycle is not counted and raises overrun.
- Argmax:
  - Lowest index wins among equal maxima.
  - tie=1 iff at least two counters equal the maximum.
  - All counts zero gives class_id=0 and tie=1 (NUM_OUT>1).
  - Saturated counters compare as their saturated value.
- output_spikes and window_len changes outside sample points have no effect.
- enable changes in HOLD take effect only at the handshake.

Test Plan:
- Reset, window_len=4, enable=1; tick 4 times with output_spikes=2'b10,10,11,10 -> 1 cycle after the 4th tick: out_valid=1, spike_counts={4,1} (neuron1=4, neuron0=1), class_id=1, tie=0.
- window_len=2, spikes 2'b11 twice -> counts {2,2}, class_id=0, tie=1. Then window_len=3 with no spikes -> counts {0,0}, class_id=0, tie=1.
- CNT_W=8, window_len=255 (run twice with alternating neuron0-only) and spikes 2'b01 every tick over 255 ticks -> neuron0 count=255. Repeat with CNT_W=4 -> neuron0 count saturates at 15, no wrap.
- Hold out_ready=0 for 10 cycles with 3 ticks in HOLD:
  - outputs stay stable and overrun pulses 3 times;
  - raising out_ready with enable=1 leaves out_valid=0 next cycle and busy=1;
  - the next window counts only post-handshake ticks.
- Drop enable after 2 of 4 ticks -> FSM returns to IDLE, out_valid never asserts, prior result unchanged.
- Assert reset while in HOLD with out_valid=1 -> next cycle out_valid=0, counts=0, busy=0. Also window_len=0 -> window closes after 1 tick.
